// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, runs a req/ack fetch from instruction
// memory on the controller's loadIR strobe and decodes opcode/operand from IR.
module fetch_unit #(
  parameter int            AW       = 8,
  parameter int            IW       = 12,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          loadIR,
  input  logic          loadPC,
  input  logic          incPC,
  input  logic [AW-1:0] target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [AW-1:0] pc,
  output logic [3:0]    opcode,
  output logic [IW-5:0] operand,
  output logic          ir_valid,
  output logic          busy,
  output logic          fetch_err
);

  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t        state;
  logic [IW-1:0] ir;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          timed_out;

  assign cnt_nxt   = cnt + 1'b1;
  assign timed_out = (TIMEOUT != 0) && (cnt_nxt == TO_LIM);

  assign opcode  = ir[IW-1 -: 4];
  assign operand = ir[IW-5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      cnt       <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      ir_valid  <= 1'b0;
      busy      <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      // PC update is independent of the fetch FSM; the request keeps its own latched address.
      if (en) begin
        if (loadPC)
          pc <= target;
        else if (incPC)
          pc <= pc + 1'b1;
      end

      case (state)
        IDLE: begin
          if (en && loadIR) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            busy      <= 1'b1;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            cnt       <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt_nxt;
            if (timed_out) begin
              imem_req  <= 1'b0;
              busy      <= 1'b0;
              fetch_err <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: stimulus pushes expected fetch outcomes,
// a negedge monitor pops and compares them when each fetch completes.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, loadIR, loadPC, incPC;
  logic [7:0]  target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [11:0] imem_rdata;
  logic [7:0]  pc;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic        ir_valid, busy, fetch_err;

  fetch_unit #(.AW(8), .IW(12), .RESET_PC(8'h00), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .loadIR(loadIR), .loadPC(loadPC),
    .incPC(incPC), .target(target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .opcode(opcode),
    .operand(operand), .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] ir;
    logic        vld;
    logic        err;
    logic [7:0]  addr;
    int          reqc;
  } exp_t;

  exp_t exp_q[$];
  int   ncmp = 0;
  int   nbad = 0;
  int   ncompl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: tracks each request window and compares against the queue when busy falls.
  logic       prev_busy = 1'b0;
  logic       in_req = 1'b0;
  logic       addr_bad = 1'b0;
  logic [7:0] addr0 = '0;
  int         reqc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      in_req    = 1'b0;
      addr_bad  = 1'b0;
    end else begin
      if (imem_req) begin
        if (!in_req) begin
          in_req   = 1'b1;
          addr0    = imem_addr;
          reqc     = 0;
          addr_bad = 1'b0;
        end
        reqc++;
        if (imem_addr !== addr0) addr_bad = 1'b1;
      end
      if (prev_busy && !busy) begin
        ncompl++;
        if (exp_q.size() == 0) begin
          ncmp++;
          nbad++;
          $display("FAIL unexpected_completion: got completion, expected none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("mon_ir", {20'd0, opcode, operand}, {20'd0, e.ir});
          chk("mon_ir_valid", {31'd0, ir_valid}, {31'd0, e.vld});
          chk("mon_fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
          chk("mon_addr", {24'd0, addr0}, {24'd0, e.addr});
          chk("mon_req_cycles", reqc, e.reqc);
          chk("mon_addr_stable", {31'd0, addr_bad}, 32'd0);
          chk("mon_req_dropped", {31'd0, imem_req}, 32'd0);
        end
        in_req = 1'b0;
      end
      prev_busy = busy;
    end
  end

  function automatic exp_t mk(input logic [11:0] ir, input logic vld, input logic err,
                              input logic [7:0] addr, input int rc);
    exp_t e;
    e.ir = ir; e.vld = vld; e.err = err; e.addr = addr; e.reqc = rc;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; loadIR = 1'b0; loadPC = 1'b0; incPC = 1'b0;
    target = '0; imem_ack = 1'b0; imem_rdata = '0;
    #3;
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_opcode", {28'd0, opcode}, 32'h0);
    chk("rst_operand", {24'd0, operand}, 32'h00);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr}, 32'h00);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single fetch, ack in first request cycle.
    exp_q.push_back(mk(12'h4A5, 1'b1, 1'b0, 8'h00, 1));
    en = 1'b1; loadIR = 1'b1;
    tick();
    loadIR = 1'b0;
    chk("f1_req", {31'd0, imem_req}, 32'd1);
    chk("f1_busy", {31'd0, busy}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 12'h4A5;
    tick();
    imem_ack = 1'b0;
    chk("f1_ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("f1_opcode", {28'd0, opcode}, 32'h4);
    chk("f1_operand", {24'd0, operand}, 32'hA5);
    chk("f1_pc", {24'd0, pc}, 32'h00);

    // Wait states with incPC during the fetch.
    loadPC = 1'b1; target = 8'h03;
    tick();
    loadPC = 1'b0;
    chk("f2_pc_load", {24'd0, pc}, 32'h03);
    exp_q.push_back(mk(12'h1FF, 1'b1, 1'b0, 8'h03, 5));
    loadIR = 1'b1;
    tick();
    loadIR = 1'b0;
    chk("f2_ir_valid_clr", {31'd0, ir_valid}, 32'd0);
    incPC = 1'b1;
    tick();
    incPC = 1'b0;
    tick(); tick(); tick();
    chk("f2_busy_wait", {31'd0, busy}, 32'd1);
    chk("f2_addr_wait", {24'd0, imem_addr}, 32'h03);
    chk("f2_pc_inc", {24'd0, pc}, 32'h04);
    imem_ack = 1'b1; imem_rdata = 12'h1FF;
    tick();
    imem_ack = 1'b0;
    chk("f2_opcode", {28'd0, opcode}, 32'h1);
    chk("f2_operand", {24'd0, operand}, 32'hFF);
    chk("f2_pc", {24'd0, pc}, 32'h04);

    // PC priority and wrap.
    loadPC = 1'b1; target = 8'hFF;
    tick();
    loadPC = 1'b0; incPC = 1'b1;
    tick();
    chk("pc_wrap", {24'd0, pc}, 32'h00);
    loadPC = 1'b1; target = 8'h20;
    tick();
    chk("pc_priority", {24'd0, pc}, 32'h20);
    en = 1'b0; target = 8'h55; loadIR = 1'b1;
    tick();
    chk("pc_en_hold", {24'd0, pc}, 32'h20);
    chk("en0_no_fetch", {31'd0, busy}, 32'd0);
    loadPC = 1'b0; incPC = 1'b0; loadIR = 1'b0; en = 1'b1;

    // Timeout with no ack.
    exp_q.push_back(mk(12'h1FF, 1'b0, 1'b1, 8'h20, 15));
    loadIR = 1'b1;
    tick();
    loadIR = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("to_req_still", {31'd0, imem_req}, 32'd1);
    chk("to_err_not_yet", {31'd0, fetch_err}, 32'd0);
    tick();
    chk("to_req_drop", {31'd0, imem_req}, 32'd0);
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("to_ir_hold", {20'd0, opcode, operand}, 32'h1FF);

    // Next fetch clears the sticky error.
    exp_q.push_back(mk(12'hABC, 1'b1, 1'b0, 8'h20, 1));
    loadIR = 1'b1;
    tick();
    loadIR = 1'b0;
    chk("err_clear", {31'd0, fetch_err}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 12'hABC;
    tick();
    imem_ack = 1'b0;
    chk("f3_ir", {20'd0, opcode, operand}, 32'hABC);

    // loadIR held while busy, then stray ack in IDLE.
    exp_q.push_back(mk(12'h321, 1'b1, 1'b0, 8'h20, 3));
    loadIR = 1'b1;
    tick();
    tick();
    loadIR = 1'b0;
    tick();
    imem_ack = 1'b1; imem_rdata = 12'h321;
    tick();
    imem_ack = 1'b0;
    chk("busy_ld_no_req", {31'd0, imem_req}, 32'd0);
    chk("busy_ld_idle", {31'd0, busy}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 12'hFFF;
    tick();
    imem_ack = 1'b0;
    chk("stray_ack_ir", {20'd0, opcode, operand}, 32'h321);
    chk("stray_ack_valid", {31'd0, ir_valid}, 32'd1);
    chk("stray_ack_busy", {31'd0, busy}, 32'd0);

    // Reset in the second fetch cycle, late ack afterwards.
    loadPC = 1'b1; target = 8'h07;
    tick();
    loadPC = 1'b0; loadIR = 1'b1;
    tick();
    loadIR = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_pc", {24'd0, pc}, 32'h00);
    tick();
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 12'h5A5;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_ir", {20'd0, opcode, operand}, 32'h000);
    chk("late_ack_valid", {31'd0, ir_valid}, 32'd0);
    tick(); tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("completions", ncompl, 32'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
